// File: rtl/bnn_pixel_unpacker.sv
// Sync-framed SPI byte stream to one-pixel-per-cycle BNN image writes.
// Payload bytes pass through a small FIFO into an 8-bit shifter.
module bnn_pixel_unpacker #(
  parameter int unsigned NUM_PIXELS = 784,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       byte_valid,
  input  logic       frame_abort,
  output logic       image_write_enable,
  output logic [7:0] image_write_data,
  output logic       clear_buffer,
  output logic       frame_done,
  output logic       overflow,
  output logic       busy,
  output logic [9:0] pixel_count
);

  localparam int unsigned NBYTES = (NUM_PIXELS + 7) / 8;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(NBYTES + 1);
  localparam logic [9:0]    LAST_PIX  = 10'(NUM_PIXELS - 1);
  localparam logic [BW-1:0] MAX_BYTES = BW'(NBYTES);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RECV, S_DONE, S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    sh_q, sh_d;
  logic [3:0]    rem_q, rem_d;
  logic [BW-1:0] acc_q, acc_d;
  logic [9:0]    pix_q, pix_d;
  logic          we_q, we_d;
  logic          bit_q, bit_d;
  logic          clr_q, clr_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;

  logic push, pop, flush;
  logic emit, last, load, accept, full;
  logic cur_pix;
  logic [7:0] shifted;

  assign cur_pix = MSB_FIRST ? sh_q[7] : sh_q[0];
  assign shifted = MSB_FIRST ? {sh_q[6:0], 1'b0}
                             : {1'b0, sh_q[7:1]};

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    pix_d   = pix_q;
    ovf_d   = ovf_q;
    we_d    = 1'b0;
    bit_d   = 1'b0;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    emit    = (rem_q != 4'd0);
    last    = emit && (pix_q == LAST_PIX);
    load    = !last && (cnt_q != '0)
              && (rem_q <= 4'd1);
    accept  = byte_valid && (acc_q < MAX_BYTES);
    full    = (cnt_q == FULL_CNT);
    unique case (state_q)
      S_IDLE: begin
        if (byte_valid && rx_byte == SYNC_BYTE
            && !frame_abort) begin
          state_d = S_CLEAR;
          clr_d   = 1'b1;
          pix_d   = '0;
          acc_d   = '0;
        end
      end
      S_CLEAR: begin
        if (frame_abort) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else begin
          state_d = S_RECV;
          push    = accept;
          acc_d   = acc_q + BW'(accept);
        end
      end
      S_RECV: begin
        if (frame_abort) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else if (accept && full && !load) begin
          state_d = S_ERR;
          ovf_d   = 1'b1;
        end else begin
          push  = accept && !last;
          acc_d = acc_q + BW'(accept);
          if (emit) begin
            we_d  = 1'b1;
            bit_d = cur_pix;
            pix_d = pix_q + 10'd1;
            sh_d  = shifted;
            rem_d = rem_q - 4'd1;
          end
          // Trailing bits of the final byte are dropped here.
          if (last) begin
            state_d = S_DONE;
            flush   = 1'b1;
          end else if (load) begin
            pop   = 1'b1;
            sh_d  = mem_q[rptr_q];
            rem_d = 4'd8;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        flush   = 1'b1;
        done_d  = !frame_abort;
      end
      S_ERR: begin
        if (frame_abort) begin
          state_d = S_IDLE;
          flush   = 1'b1;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) rem_d = 4'd0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      pix_q   <= '0;
      we_q    <= 1'b0;
      bit_q   <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      pix_q   <= pix_d;
      we_q    <= we_d;
      bit_q   <= bit_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= rx_byte;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign image_write_enable = we_q;
  assign image_write_data   = {7'b0, bit_q};
  assign clear_buffer       = clr_q;
  assign frame_done         = done_q;
  assign overflow           = ovf_q;
  assign busy               = busy_q;
  assign pixel_count        = pix_q;

endmodule

// File: tb/tb_bnn_pixel_unpacker.sv
// Directed bench for bnn_pixel_unpacker with a pixel scoreboard.
// u0 uses default parameters; u1 is a 10-pixel LSB-first frame.
module tb_bnn_pixel_unpacker;

  logic       clk;
  logic       rst_n;
  logic [7:0] rxb0, rxb1;
  logic       vld0, vld1, abt0, abt1;
  logic       we0, we1, clr0, clr1;
  logic       done0, done1, ovf0, ovf1;
  logic       busy0, busy1;
  logic [7:0] wd0, wd1;
  logic [9:0] pc0, pc1;

  int tests, fails;
  int cyc;
  int wcnt0, wcnt1, dcnt0, dcnt1;
  int lastw0, lastw1;
  int mpix0, mpix1;
  bit q0[$];
  bit q1[$];

  bnn_pixel_unpacker u0 (
    .clk(clk), .rst_n(rst_n),
    .rx_byte(rxb0), .byte_valid(vld0),
    .frame_abort(abt0),
    .image_write_enable(we0),
    .image_write_data(wd0),
    .clear_buffer(clr0), .frame_done(done0),
    .overflow(ovf0), .busy(busy0),
    .pixel_count(pc0)
  );

  bnn_pixel_unpacker #(
    .NUM_PIXELS(10), .SYNC_BYTE(8'hA5),
    .FIFO_DEPTH(4), .MSB_FIRST(1'b0)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .rx_byte(rxb1), .byte_valid(vld1),
    .frame_abort(abt1),
    .image_write_enable(we1),
    .image_write_data(wd1),
    .clear_buffer(clr1), .frame_done(done1),
    .overflow(ovf1), .busy(busy1),
    .pixel_count(pc1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    bit e;
    if (we0) begin
      chk("wr0_expected", int'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("wr0_data", int'(wd0), int'(e));
      end
      wcnt0++;
      lastw0 = cyc;
    end
    if (done0) begin
      dcnt0++;
      chk("done0_gap", cyc, lastw0 + 1);
    end
  end

  always @(negedge clk) begin
    bit e;
    if (we1) begin
      chk("wr1_expected", int'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("wr1_data", int'(wd1), int'(e));
      end
      wcnt1++;
      lastw1 = cyc;
    end
    if (done1) begin
      dcnt1++;
      chk("done1_gap", cyc, lastw1 + 1);
    end
  end

  // Frame model: bit order and pixel limit per instance.
  task automatic push_exp(input int u, input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (u == 0) begin
        if (mpix0 < 784) begin
          q0.push_back(b[7-i]);
          mpix0++;
        end
      end else begin
        if (mpix1 < 10) begin
          q1.push_back(b[i]);
          mpix1++;
        end
      end
    end
  endtask

  task automatic send(input int u, input logic [7:0] b,
                      input bit pay);
    if (pay) push_exp(u, b);
    if (u == 0) begin
      rxb0 = b;
      vld0 = 1'b1;
    end else begin
      rxb1 = b;
      vld1 = 1'b1;
    end
    @(negedge clk);
    vld0 = 1'b0;
    vld1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int u, input int budget);
    bit found;
    int pc;
    found = 0;
    pc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((u == 0) ? done0 : done1) begin
        found = 1;
        pc = (u == 0) ? int'(pc0) : int'(pc1);
        break;
      end
    end
    chk("done_seen", int'(found), 1);
    if (found) chk("done_pcount", pc, (u == 0) ? 784 : 10);
  endtask

  task automatic flush_model();
    q0.delete();
    q1.delete();
    mpix0 = 0;
    mpix1 = 0;
  endtask

  initial begin
    int base, dbase, hold;
    logic [7:0] b;
    tests = 0; fails = 0; cyc = 0;
    wcnt0 = 0; wcnt1 = 0; dcnt0 = 0; dcnt1 = 0;
    lastw0 = -10; lastw1 = -10;
    mpix0 = 0; mpix1 = 0;
    rst_n = 1'b0;
    rxb0 = '0; rxb1 = '0;
    vld0 = 0; vld1 = 0; abt0 = 0; abt1 = 0;

    // Reset state
    idle(3);
    chk("rst_we", int'(we0), 0);
    chk("rst_clr", int'(clr0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_ovf", int'(ovf0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_pc", int'(pc0), 0);
    chk("rst_wd", int'(wd0), 0);
    chk("rst_busy1", int'(busy1), 0);
    rst_n = 1'b1;
    idle(2);

    // Nominal frame of 0xAA
    base = wcnt0; dbase = dcnt0;
    send(0, 8'hA5, 0);
    chk("nom_clr", int'(clr0), 1);
    chk("nom_clr_we", int'(we0), 0);
    chk("nom_clr_pc", int'(pc0), 0);
    chk("nom_busy", int'(busy0), 1);
    for (int k = 0; k < 98; k++) begin
      send(0, 8'hAA, 1);
      if (k == 0) chk("nom_clr_once", int'(clr0), 0);
      idle(7);
    end
    wait_done(0, 40);
    idle(3);
    chk("nom_writes", wcnt0 - base, 784);
    chk("nom_dones", dcnt0 - dbase, 1);
    chk("nom_ovf", int'(ovf0), 0);
    chk("nom_q_empty", q0.size(), 0);
    chk("nom_busy_end", int'(busy0), 0);
    flush_model();

    // Ordering, latency, then abort after ~300 pixels
    base = wcnt0; dbase = dcnt0;
    send(0, 8'hA5, 0);
    send(0, 8'h81, 1);
    chk("lat_e0", int'(we0), 0);
    idle(1);
    chk("lat_e1", int'(we0), 0);
    idle(1);
    chk("lat_e2_we", int'(we0), 1);
    chk("lat_e2_data", int'(wd0), 1);
    for (int k = 0; k < 40; k++) begin
      send(0, 8'(k * 37 + 5), 1);
      idle(7);
      if (wcnt0 - base >= 300) break;
    end
    chk("abt_reached300", int'(wcnt0 - base >= 300), 1);
    abt0 = 1'b1;
    @(negedge clk);
    abt0 = 1'b0;
    chk("abt_busy", int'(busy0), 0);
    chk("abt_we", int'(we0), 0);
    flush_model();
    hold = int'(pc0);
    idle(5);
    chk("abt_pc_hold", int'(pc0), hold);
    chk("abt_no_done", dcnt0 - dbase, 0);
    send(0, 8'hA5, 0);
    chk("abt_resync_clr", int'(clr0), 1);
    chk("abt_resync_pc", int'(pc0), 0);
    abt0 = 1'b1;
    @(negedge clk);
    abt0 = 1'b0;
    chk("abt2_busy", int'(busy0), 0);
    idle(2);

    // IDLE: abort with coincident sync drops the sync
    rxb0 = 8'hA5; vld0 = 1'b1; abt0 = 1'b1;
    @(negedge clk);
    vld0 = 1'b0; abt0 = 1'b0;
    chk("idle_abt_busy", int'(busy0), 0);
    chk("idle_abt_clr", int'(clr0), 0);

    // Pre-sync junk, random payload, trailing extras
    base = wcnt0; dbase = dcnt0;
    send(0, 8'h00, 0);
    idle(3);
    send(0, 8'h55, 0);
    idle(3);
    chk("junk_busy", int'(busy0), 0);
    chk("junk_writes", wcnt0 - base, 0);
    send(0, 8'hA5, 0);
    for (int k = 0; k < 98; k++) begin
      b = 8'($urandom_range(0, 255));
      send(0, b, 1);
      idle(7);
    end
    send(0, 8'h5A, 0);
    idle(7);
    send(0, 8'h3C, 0);
    idle(7);
    send(0, 8'h11, 0);
    idle(20);
    chk("junk_total", wcnt0 - base, 784);
    chk("junk_dones", dcnt0 - dbase, 1);
    chk("junk_pc", int'(pc0), 784);
    chk("junk_q_empty", q0.size(), 0);
    flush_model();

    // Overflow on the 6th back-to-back payload byte
    base = wcnt0;
    send(0, 8'hA5, 0);
    for (int k = 0; k < 5; k++) begin
      send(0, 8'hF0 + 8'(k), 1);
    end
    chk("ovf_pre", int'(ovf0), 0);
    send(0, 8'h77, 0);
    chk("ovf_set", int'(ovf0), 1);
    chk("ovf_busy", int'(busy0), 1);
    hold = wcnt0;
    idle(20);
    chk("ovf_writes_stop", wcnt0 - hold, 0);
    chk("ovf_writes", wcnt0 - base, 3);
    chk("ovf_held", int'(ovf0), 1);
    chk("ovf_err_busy", int'(busy0), 1);
    abt0 = 1'b1;
    @(negedge clk);
    abt0 = 1'b0;
    chk("ovf_abt_busy", int'(busy0), 0);
    chk("ovf_abt_clr", int'(ovf0), 0);
    flush_model();
    idle(2);

    // Small frame, LSB first: 2 bytes, 10 pixels
    base = wcnt1; dbase = dcnt1;
    send(1, 8'hA5, 0);
    send(1, 8'h01, 1);
    idle(2);
    chk("lsb_we", int'(we1), 1);
    chk("lsb_first", int'(wd1), 1);
    idle(5);
    send(1, 8'hFF, 1);
    wait_done(1, 40);
    idle(3);
    chk("small_writes", wcnt1 - base, 10);
    chk("small_dones", dcnt1 - dbase, 1);
    chk("small_q_empty", q1.size(), 0);
    flush_model();

    // Abort coincident with the 10th write
    base = wcnt1; dbase = dcnt1;
    send(1, 8'hA5, 0);
    send(1, 8'h6C, 1);
    idle(7);
    send(1, 8'h03, 1);
    idle(2);
    abt1 = 1'b1;
    @(negedge clk);
    abt1 = 1'b0;
    chk("coinc_we", int'(we1), 0);
    chk("coinc_busy", int'(busy1), 0);
    idle(4);
    chk("coinc_writes", wcnt1 - base, 9);
    chk("coinc_pc", int'(pc1), 9);
    chk("coinc_no_done", dcnt1 - dbase, 0);
    flush_model();

    // Reset mid-frame
    dbase = dcnt0;
    send(0, 8'hA5, 0);
    send(0, 8'hFF, 1);
    idle(2);
    chk("mid_we_before", int'(we0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_we", int'(we0), 0);
    chk("mid_wd", int'(wd0), 0);
    chk("mid_busy", int'(busy0), 0);
    chk("mid_pc", int'(pc0), 0);
    chk("mid_clr", int'(clr0), 0);
    chk("mid_done", int'(done0), 0);
    chk("mid_ovf", int'(ovf0), 0);
    flush_model();
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    chk("mid_no_done", dcnt0 - dbase, 0);
    chk("mid_idle", int'(busy0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
